// File: rtl/descriptor_gradient_line_buffer_if.sv
// Stream interface between the gradient source and the line buffer.
// The master drives samples in; the slave returns WIN-row columns.
interface descriptor_gradient_line_buffer_if #(
  parameter int GRAD_W = 16,
  parameter int WIN    = 4,
  parameter int COL_W  = 9,
  parameter int ROW_W  = 8
);
  logic                    ivalid;
  logic                    isof;
  logic [GRAD_W-1:0]       igradient;
  logic                    ovalid;
  logic [WIN*GRAD_W-1:0]   ogradient;
  logic [ROW_W-1:0]        orow;
  logic [COL_W-1:0]        ocol;
  logic                    oframe_done;

  modport master (
    output ivalid, isof, igradient,
    input  ovalid, ogradient, orow, ocol, oframe_done
  );

  modport slave (
    input  ivalid, isof, igradient,
    output ovalid, ogradient, orow, ocol, oframe_done
  );
endinterface

// File: rtl/descriptor_gradient_line_buffer.sv
// Chained line memories that turn a raster gradient stream into vertical
// WIN-sample columns for the descriptor window-hold stage.
module descriptor_gradient_line_buffer #(
  parameter int GRAD_W = 16,
  parameter int WIN    = 4,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int COL_W  = 9,
  parameter int ROW_W  = 8
) (
  input  logic iclk,
  input  logic ireset,
  descriptor_gradient_line_buffer_if.slave bus
);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN - 1);

  logic [COL_W-1:0]      col, cur_col;
  logic [ROW_W-1:0]      row, cur_row;
  logic                  accept;
  logic [GRAD_W-1:0]     line_mem [WIN-1][IMG_W];
  logic [GRAD_W-1:0]     line_rd  [WIN-1];

  logic                  out_valid;
  logic [WIN*GRAD_W-1:0] out_gradient;
  logic [ROW_W-1:0]      out_row;
  logic [COL_W-1:0]      out_col;
  logic                  out_frame_done;

  assign accept = bus.ivalid;

  // A start-of-frame sample overrides whatever position the counters hold.
  always_comb begin
    cur_col = bus.isof ? '0 : col;
    cur_row = bus.isof ? '0 : row;
  end

  always_comb begin
    for (int j = 0; j < WIN - 1; j++) line_rd[j] = line_mem[j][cur_col];
  end

  // Read-before-write: each line stores the value it just handed on,
  // giving exactly one row of delay per line.
  always_ff @(posedge iclk) begin
    if (accept) begin
      line_mem[0][cur_col] <= bus.igradient;
      for (int j = 0; j < WIN - 2; j++) line_mem[j+1][cur_col] <= line_rd[j];
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      col            <= '0;
      row            <= '0;
      out_valid      <= 1'b0;
      out_gradient   <= '0;
      out_row        <= '0;
      out_col        <= '0;
      out_frame_done <= 1'b0;
    end else begin
      out_valid      <= accept && (cur_row >= ROW_FIRST);
      out_frame_done <= accept && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (accept) begin
        out_gradient[GRAD_W-1:0] <= bus.igradient;
        for (int k = 1; k < WIN; k++) out_gradient[GRAD_W*k +: GRAD_W] <= line_rd[k-1];
        out_row <= cur_row;
        out_col <= cur_col;
        if (cur_col == COL_LAST) begin
          col <= '0;
          row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

  assign bus.ovalid      = out_valid;
  assign bus.ogradient   = out_gradient;
  assign bus.orow        = out_row;
  assign bus.ocol        = out_col;
  assign bus.oframe_done = out_frame_done;
endmodule
